// File: rtl/lg2_pkg.sv
// Shared floating-point helpers for the lg2/ex2 processing path.
// Widths, bias, field extraction, special constants and operand classes.
package lg2_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 7;
  localparam int FP_WIDTH = 1 + FP_EXP_W + FP_MAN_W;
  localparam int FP_BIAS  = (1 << (FP_EXP_W - 1)) - 1;

  typedef logic [FP_WIDTH-1:0] fp_t;

  localparam fp_t FP_QNAN = {1'b0, {FP_EXP_W{1'b1}},
                             1'b1, {(FP_MAN_W-1){1'b0}}};
  localparam fp_t FP_PINF = {1'b0, {FP_EXP_W{1'b1}},
                             {FP_MAN_W{1'b0}}};
  localparam fp_t FP_NINF = {1'b1, {FP_EXP_W{1'b1}},
                             {FP_MAN_W{1'b0}}};

  typedef enum logic [1:0] {
    CLS_NORM,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } cls_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_NORM,
    S_DONE
  } lg2_state_e;

  function automatic logic fp_sign(input fp_t x);
    return x[FP_WIDTH-1];
  endfunction

  function automatic logic [FP_EXP_W-1:0] fp_exp(input fp_t x);
    return x[FP_WIDTH-2 -: FP_EXP_W];
  endfunction

  function automatic logic [FP_MAN_W-1:0] fp_man(input fp_t x);
    return x[FP_MAN_W-1:0];
  endfunction

endpackage

// File: rtl/lg2_norm.sv
// Fixed-point to float packer: signed V with FRAC_BITS fraction bits.
// Ports: v_i (signed fixed-point in), f_o (float {sign, exp, man} out).
module lg2_norm
  import lg2_pkg::*;
#(
  parameter int EXP_W     = FP_EXP_W,
  parameter int MAN_W     = FP_MAN_W,
  parameter int FRAC_BITS = 16,
  parameter int WIDTH     = 1 + EXP_W + MAN_W
) (
  input  logic [EXP_W+FRAC_BITS:0] v_i,
  output logic [WIDTH-1:0]         f_o
);

  localparam int V_W  = EXP_W + 1 + FRAC_BITS;
  localparam int PW   = $clog2(V_W);
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;

  logic                   neg;
  logic [V_W-1:0]         mag;
  logic [V_W-1:0]         shifted;
  logic [PW-1:0]          p;
  logic [PW-1:0]          sh;
  logic                   lead_unused;
  logic [MAN_W-1:0]       mant;
  logic [V_W-MAN_W-2:0]   tail_unused;
  logic [31:0]            e32;
  logic [31-EXP_W:0]      e_hi_unused;
  logic [EXP_W-1:0]       e_f;

  assign neg = v_i[V_W-1];
  assign mag = neg ? (~v_i + V_W'(1)) : v_i;

  always_comb begin
    p = '0;
    for (int i = 0; i < V_W; i++) begin
      if (mag[i]) p = PW'(i);
    end
  end

  // Leading one moved to the MSB; bits below it become the mantissa.
  assign sh      = PW'(V_W - 1) - p;
  assign shifted = mag << sh;
  assign {lead_unused, mant, tail_unused} = shifted;

  assign e32 = 32'(BIAS) + 32'(p) - 32'(FRAC_BITS);
  assign {e_hi_unused, e_f} = e32;

  assign f_o = (mag == '0) ? '0 : {neg, e_f, mant};

endmodule

// File: rtl/lg2.sv
// Iterative base-2 logarithm: exponent gives the integer part, repeated
// squaring of the mantissa gives one fraction bit per cycle.
// Ports: clk, rst_n, in_valid/in_ready/in, out_valid/out_ready/out.
module lg2
  import lg2_pkg::*;
#(
  parameter int EXP_W     = FP_EXP_W,
  parameter int MAN_W     = FP_MAN_W,
  parameter int WIDTH     = 1 + EXP_W + MAN_W,
  parameter int FRAC_BITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
);

  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int INT_W = EXP_W + 1;
  localparam int YF    = MAN_W + 4;
  localparam int Y_W   = YF + 1;
  localparam int SQ_W  = 2 * Y_W;
  localparam int CNT_W = $clog2(FRAC_BITS);

  localparam logic [WIDTH-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [WIDTH-1:0] PINF =
    {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [WIDTH-1:0] NINF =
    {1'b1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

  lg2_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [INT_W-1:0]   int_q;
  logic [Y_W-1:0]     y_q;
  logic [FRAC_BITS-1:0] frac_q;
  cls_e               cls_q, cls_d;
  logic [WIDTH-1:0]   out_q;
  logic               out_valid_q;

  logic               accept;
  logic               in_s;
  logic [EXP_W-1:0]   in_e;
  logic [MAN_W-1:0]   in_m;
  logic               e_zero, e_max;
  logic [Y_W:0]       sq_hi;
  logic [YF-1:0]      sq_unused;
  logic               sq_ge2;
  logic [Y_W-1:0]     y_sq;
  logic [WIDTH-1:0]   norm_f;
  logic [WIDTH-1:0]   res;

  assign {in_s, in_e, in_m} = in;
  assign e_zero = (in_e == '0);
  assign e_max  = (in_e == '1);

  always_comb begin
    cls_d = CLS_NORM;
    unique case (1'b1)
      e_zero:                              cls_d = CLS_ZERO;
      e_max && (in_s || in_m != '0):       cls_d = CLS_NAN;
      e_max && !in_s && in_m == '0:        cls_d = CLS_INF;
      !e_zero && !e_max && in_s:           cls_d = CLS_NAN;
      default:                             cls_d = CLS_NORM;
    endcase
  end

  // y is Q1.YF; the square is Q2.(2*YF), truncated back to Q2.YF.
  assign {sq_hi, sq_unused} = SQ_W'(y_q) * SQ_W'(y_q);
  assign sq_ge2 = sq_hi[Y_W];
  assign y_sq   = sq_ge2 ? sq_hi[Y_W:1] : sq_hi[Y_W-1:0];

  lg2_norm #(
    .EXP_W     (EXP_W),
    .MAN_W     (MAN_W),
    .FRAC_BITS (FRAC_BITS),
    .WIDTH     (WIDTH)
  ) u_norm (
    .v_i ({int_q, frac_q}),
    .f_o (norm_f)
  );

  always_comb begin
    res = norm_f;
    unique case (cls_q)
      CLS_ZERO: res = NINF;
      CLS_INF:  res = PINF;
      CLS_NAN:  res = QNAN;
      default:  res = norm_f;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (in_valid) state_d = S_ITER;
      S_ITER: if (cnt_q == '0) state_d = S_NORM;
      S_NORM: state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_IDLE);
    accept   = in_ready && in_valid;
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      int_q       <= '0;
      y_q         <= '0;
      frac_q      <= '0;
      cls_q       <= CLS_NORM;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        int_q  <= {1'b0, in_e} - INT_W'(BIAS);
        y_q    <= {1'b1, in_m, {(YF-MAN_W){1'b0}}};
        frac_q <= '0;
        cls_q  <= cls_d;
        cnt_q  <= CNT_W'(FRAC_BITS - 1);
      end
      if (state_q == S_ITER) begin
        y_q    <= y_sq;
        frac_q <= {frac_q[FRAC_BITS-2:0], sq_ge2};
        cnt_q  <= cnt_q - CNT_W'(1);
      end
      if (state_q == S_NORM) begin
        out_q       <= res;
        out_valid_q <= 1'b1;
      end
      if (state_q == S_DONE && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/lg2.md
# lg2

Iterative base-2 logarithm of a floating-point operand; the inverse companion of the `ex2` power unit in the floating-point processing path. It splits the operand into unbiased exponent (integer part) and log2 of the mantissa (fraction part, one bit per cycle by repeated squaring), then renormalises the fixed-point result to float. It has fixed latency and valid/ready handshakes on both sides, so the processing pipeline can stall it.

## Interface
- `EXP_W`, 8, exponent field width; bias = 2^(EXP_W-1)-1
- `MAN_W`, 7, stored mantissa width
- `WIDTH`, 1+EXP_W+MAN_W, operand width: {sign, exponent, mantissa}
- `FRAC_BITS`, 16, fraction bits produced by the squaring loop
- `clk` in 1: clock; the only clock, all flops on rising edge
- `rst_n` in 1: asynchronous active-low reset
- `in_valid` in 1: operand valid
- `in_ready` out 1: block can accept an operand
- `in` in WIDTH: operand x
- `out_valid` out 1: result valid
- `out_ready` in 1: consumer accepts result
- `out` out WIDTH: log2(x)

## Operation
- FSM states: IDLE, ITER, NORM, DONE. Reset → IDLE; `in_ready`=1, `out_valid`=0, `out`=0.
- IDLE: `in_ready`=1. On `in_valid`: latch int = e−bias as a signed EXP_W+1-bit value; latch y = 1.m in Q1.(MAN_W+4), with 4 guard bits zero; latch the special class. Go to ITER, counter=FRAC_BITS−1.
- ITER: y ← y² truncated to Q2.(MAN_W+4). If y ≥ 2, emit fraction bit 1 and set y ← y/2; else emit 0. Fraction bits are shifted in MSB first. At counter 0, go to NORM.
- NORM: V = {int, frac} is a signed fixed-point value with FRAC_BITS fraction bits.
  - If V=0, result is +0.
  - Otherwise sign = V<0, and |V| is the two's-complement negation of V when V<0.
  - p is the leading-one index of |V|.
  - Exponent = bias + p − FRAC_BITS.
  - Mantissa = the MAN_W bits directly below the leading one, truncated; zero-filled if p<MAN_W.
  - Go to DONE.
- Specials are classified at capture; they override the NORM result but the timing is unchanged:
  - exp=0 (zero/denormal, flushed) → −inf
  - sign=1 and nonzero → canonical NaN {0, all-ones, 1, 0…}
  - +inf → +inf
  - NaN → canonical NaN
- DONE: `out_valid`=1. `out` is held stable until `out_ready`, then go to IDLE. `in_ready`=0 in DONE, so there is no same-cycle turnaround.
- `rst_n` low in any state: immediate IDLE, `out_valid`=0, the in-flight operand is discarded.

## Timing
- Accept in cycle T (`in_valid`&&`in_ready`).
- ITER occupies T+1..T+FRAC_BITS. NORM is T+FRAC_BITS+1. `out_valid` rises at T+FRAC_BITS+2, which is 18 cycles for default parameters.
- Throughput: one result per FRAC_BITS+3 cycles with `out_ready` tied high.
- `in_ready` drops the cycle after accept. It returns the cycle after the output handshake.
- `out` and `out_valid` are registered. `in_ready` is decoded from state only.

## Structure
- Shared FP package: `EXP_W`, `MAN_W`, `WIDTH`, bias, field-extract functions, canonical NaN/inf constants, special-class enum. The same package serves `ex2`.
- One natural sub-module: `lg2_norm`, a combinational leading-one detect plus shift that packs the fixed-point value V into a float. It is reusable for fixed→float conversion elsewhere.
- The squaring multiplier stays inline: (MAN_W+5)² bits.

## Test plan
Default parameters (bf16-like, bias 127):
1. 0x3F80 (1.0) → 0x0000; 0x4000 (2.0) → 0x3F80; 0x4100 (8.0) → 0x4040. `out_valid` appears exactly 18 cycles after accept.
2. 0x3F00 (0.5) → 0xBF80; 0x3FB5 (≈√2) → 0x3EFF (truncated 0.498).
3. Specials:
   - 0x0000 → 0xFF80
   - 0x0001 (denormal) → 0xFF80
   - 0xBF80 → 0x7FC0
   - 0x7F80 → 0x7F80
   - 0x7FC1 → 0x7FC0
4. Back-pressure: hold `out_ready`=0 for 5 cycles → `out` stable, `in_ready`=0 throughout. Release → one handshake, `in_ready`=1 the next cycle.
5. Back-to-back with `out_ready`=1: 100 random positive normals vs a real-valued log2 model truncated to MAN_W bits. Allow ±1 ulp for results with |x−1|<2^−4, exact elsewhere.
6. Assert `rst_n` at cycle T+7 mid-ITER → `out_valid` stays 0, `in_ready`=1 after release. A new operand 0x4000 → 0x3F80 with no residue from the discarded operand.
